// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between CPU (0) and DBG (1).
// Define DMEM_RANGE_CHECK_EN to reject addresses >= DEPTH with an err pulse instead of truncating.
module dmem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned MEM_AW = 12,
  parameter int unsigned DEPTH  = 4096,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;
  typedef enum logic {OWN_CPU, OWN_DBG} owner_e;

  localparam logic [ADDR_W-1:0] DEPTH_LIM = ADDR_W'(DEPTH);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_owner_q, last_owner_d;
  logic              cmd_we_q, cmd_we_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic              dbg_rvalid_q, dbg_rvalid_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              oob;
  logic              gnt;

`ifdef DMEM_RANGE_CHECK_EN
  assign oob = (cmd_addr_q >= DEPTH_LIM);
`else
  logic unused_range;
  assign oob          = 1'b0;
  assign unused_range = ^{cmd_addr_q[ADDR_W-1:MEM_AW], DEPTH_LIM};
`endif

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cmd_we_d     = cmd_we_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_wdata_d  = cmd_wdata_q;
    cpu_rvalid_d = 1'b0;
    dbg_rvalid_d = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    gnt          = 1'b0;
    mem_req      = 1'b0;
    err          = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req || dbg_req) begin
          if (cpu_req && dbg_req) begin
            owner_d = (last_owner_q == OWN_CPU) ? OWN_DBG : OWN_CPU;
          end else begin
            owner_d = cpu_req ? OWN_CPU : OWN_DBG;
          end
          cmd_we_d    = (owner_d == OWN_CPU) ? cpu_we    : dbg_we;
          cmd_addr_d  = (owner_d == OWN_CPU) ? cpu_addr  : dbg_addr;
          cmd_wdata_d = (owner_d == OWN_CPU) ? cpu_wdata : dbg_wdata;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (oob) begin
          // Rejected command never reaches memory; a load completes locally with zero data.
          gnt          = 1'b1;
          err          = 1'b1;
          last_owner_d = owner_q;
          state_d      = IDLE;
          if (!cmd_we_q) begin
            if (owner_q == OWN_CPU) begin
              cpu_rvalid_d = 1'b1;
              cpu_rdata_d  = '0;
            end else begin
              dbg_rvalid_d = 1'b1;
              dbg_rdata_d  = '0;
            end
          end
        end else begin
          mem_req = 1'b1;
          if (mem_ready) begin
            gnt          = 1'b1;
            last_owner_d = owner_q;
            state_d      = cmd_we_q ? IDLE : RESP;
          end
        end
      end
      RESP: begin
        if (mem_rvalid) begin
          if (owner_q == OWN_CPU) begin
            cpu_rvalid_d = 1'b1;
            cpu_rdata_d  = mem_rdata;
          end else begin
            dbg_rvalid_d = 1'b1;
            dbg_rdata_d  = mem_rdata;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // An aborted command must not be accepted by memory or granted during reset.
    if (!rst_n) begin
      gnt     = 1'b0;
      mem_req = 1'b0;
      err     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= OWN_CPU;
      last_owner_q <= OWN_DBG;
      cmd_we_q     <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cmd_we_q     <= cmd_we_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_wdata_q  <= cmd_wdata_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  assign cpu_gnt    = gnt && (owner_q == OWN_CPU);
  assign dbg_gnt    = gnt && (owner_q == OWN_DBG);
  assign cpu_rvalid = cpu_rvalid_q;
  assign dbg_rvalid = dbg_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign dbg_rdata  = dbg_rdata_q;
  assign mem_we     = cmd_we_q;
  assign mem_addr   = cmd_addr_q[MEM_AW-1:0];
  assign mem_wdata  = cmd_wdata_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized back-to-back traffic
// checked against a queue/array model of memory contents and round-robin ownership.
module tb_dmem_arbiter;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned MEM_AW = 12;
  localparam int unsigned DEPTH  = 4096;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NOPS   = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic              dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata, dbg_rdata;
  logic              mem_req, mem_we, mem_ready, mem_rvalid, busy, err;
  logic [MEM_AW-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  dmem_arbiter #(.ADDR_W(ADDR_W), .MEM_AW(MEM_AW), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy), .err(err)
  );

  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [31:0] data;
  } op_t;

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  logic [31:0] mem_arr [0:4095];
  logic [31:0] ref_mem [int unsigned];

  logic        pend, inject_rvalid, ready_rand;
  logic [11:0] pend_addr;
  int unsigned rd_lat, lat_cnt, stall_cnt;

  logic        o_cpu_gnt, o_dbg_gnt, o_cpu_rvalid, o_dbg_rvalid, o_mem_req, o_mem_we, o_busy, o_err;
  logic [31:0] o_cpu_rdata, o_dbg_rdata, o_mem_wdata;
  logic [11:0] o_mem_addr;

  function automatic logic [31:0] init_pat(int unsigned a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] exp_val(int unsigned a);
    return ref_mem.exists(a) ? ref_mem[a] : init_pat(a);
  endfunction

  // One clock cycle: observe at negedge, then drive memory responses just after posedge.
  task automatic tick();
    @(negedge clk);
    o_cpu_gnt = cpu_gnt;       o_dbg_gnt = dbg_gnt;
    o_cpu_rvalid = cpu_rvalid; o_dbg_rvalid = dbg_rvalid;
    o_cpu_rdata = cpu_rdata;   o_dbg_rdata = dbg_rdata;
    o_mem_req = mem_req;       o_mem_we = mem_we;
    o_mem_addr = mem_addr;     o_mem_wdata = mem_wdata;
    o_busy = busy;             o_err = err;
    if (mem_req && mem_ready) begin
      if (mem_we) mem_arr[mem_addr] = mem_wdata;
      else begin
        pend = 1'b1; pend_addr = mem_addr; lat_cnt = rd_lat;
      end
    end
    @(posedge clk);
    #1;
    mem_rvalid = 1'b0;
    if (inject_rvalid) begin
      mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF; inject_rvalid = 1'b0;
    end else if (pend) begin
      if (lat_cnt == 0) begin
        mem_rvalid = 1'b1; mem_rdata = mem_arr[pend_addr]; pend = 1'b0;
      end else lat_cnt--;
    end
    if (ready_rand) mem_ready = 1'($urandom_range(0, 1));
    else if (stall_cnt != 0) begin
      mem_ready = 1'b0; stall_cnt--;
    end else mem_ready = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cpu_req = 1'b0; dbg_req = 1'b0;
    ready_rand = 1'b0; stall_cnt = 0; pend = 1'b0; mem_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'd1; cpu_wdata = 32'h0000_1111;
    tick(); tick();
    vectors++;
    if ({o_busy, o_mem_req, o_cpu_gnt, o_cpu_rvalid, o_dbg_gnt, o_dbg_rvalid, o_err} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs got busy/mreq/cgnt/crv/dgnt/drv/err=%b exp=0000000",
               {o_busy, o_mem_req, o_cpu_gnt, o_cpu_rvalid, o_dbg_gnt, o_dbg_rvalid, o_err});
    end
    vectors++;
    if ({o_cpu_rdata, o_dbg_rdata} !== 64'h0) begin
      errors++; $display("FAIL reset_rdata got %h/%h exp 0/0", o_cpu_rdata, o_dbg_rdata);
    end
    rst_n = 1'b1;
    tick();
    vectors++;
    if (o_cpu_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt_early got %b exp 0", o_cpu_gnt); end
    tick();
    vectors++;
    if (o_cpu_gnt !== 1'b1 || o_mem_addr !== 12'd1) begin
      errors++; $display("FAIL reset_gnt_second got gnt=%b addr=%0d exp gnt=1 addr=1", o_cpu_gnt, o_mem_addr);
    end
    ref_mem[1] = 32'h0000_1111;
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_store_load();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'd5; cpu_wdata = 32'h1234_5678;
    tick(); tick();
    vectors++;
    if ({o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_cpu_gnt, o_dbg_gnt} !== {2'b11, 12'd5, 32'h1234_5678, 2'b10}) begin
      errors++;
      $display("FAIL store_issue got req=%b we=%b addr=%0d wd=%h cg=%b dg=%b exp 1 1 5 12345678 1 0",
               o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_cpu_gnt, o_dbg_gnt);
    end
    ref_mem[5] = 32'h1234_5678;
    cpu_req = 1'b0;
    tick();
    vectors++;
    if (o_cpu_gnt !== 1'b0) begin errors++; $display("FAIL store_gnt_width got %b exp 0", o_cpu_gnt); end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd5; cpu_wdata = 32'h0;
    tick(); tick();
    vectors++;
    if (o_cpu_gnt !== 1'b1 || o_mem_we !== 1'b0) begin
      errors++; $display("FAIL load_gnt got gnt=%b we=%b exp gnt=1 we=0", o_cpu_gnt, o_mem_we);
    end
    cpu_req = 1'b0;
    tick(); tick();
    vectors++;
    if (o_cpu_rvalid !== 1'b1 || o_cpu_rdata !== 32'h1234_5678 || o_dbg_rvalid !== 1'b0) begin
      errors++; $display("FAIL load_return got rv=%b rd=%h drv=%b exp rv=1 rd=12345678 drv=0",
                         o_cpu_rvalid, o_cpu_rdata, o_dbg_rvalid);
    end
    tick();
    vectors++;
    if (o_cpu_rvalid !== 1'b0 || o_cpu_rdata !== 32'h1234_5678) begin
      errors++; $display("FAIL load_hold got rv=%b rd=%h exp rv=0 rd=12345678", o_cpu_rvalid, o_cpu_rdata);
    end
  endtask

  task automatic test_contention();
    int unsigned n_cpu = 0, n_dbg = 0, ng = 0;
    logic exp_dbg = 1'b0;
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hC000_0000;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h11; dbg_wdata = 32'hD000_0000;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      tick();
      vectors++;
      if (o_cpu_gnt && o_dbg_gnt) begin errors++; $display("FAIL contention_both_gnt got 11 exp one-hot"); end
      if (o_cpu_gnt || o_dbg_gnt) begin
        vectors++;
        if (o_dbg_gnt !== exp_dbg) begin
          errors++; $display("FAIL contention_order grant %0d got dbg=%b exp dbg=%b", ng, o_dbg_gnt, exp_dbg);
        end
        if (o_dbg_gnt) begin
          ref_mem[32'(dbg_addr)] = dbg_wdata;
          n_dbg++;
          dbg_addr = 32'h11 + 32'(2 * n_dbg); dbg_wdata = 32'hD000_0000 + 32'(n_dbg);
          if (n_dbg == 2) dbg_req = 1'b0;
        end else begin
          ref_mem[32'(cpu_addr)] = cpu_wdata;
          n_cpu++;
          cpu_addr = 32'h10 + 32'(2 * n_cpu); cpu_wdata = 32'hC000_0000 + 32'(n_cpu);
          if (n_cpu == 2) cpu_req = 1'b0;
        end
        exp_dbg = !exp_dbg;
        ng++;
      end
    end
    vectors++;
    if (ng != 4) begin errors++; $display("FAIL contention_timeout got %0d grants exp 4", ng); end
  endtask

  task automatic test_wait_states();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h2A; cpu_wdata = 32'hA5A5_0F0F;
    stall_cnt = 3;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if ({o_mem_req, o_mem_addr, o_mem_wdata, o_cpu_gnt, o_cpu_rvalid} !== {1'b1, 12'h2A, 32'hA5A5_0F0F, (i == 3), 1'b0}) begin
        errors++;
        $display("FAIL wait_cycle%0d got req=%b addr=%h wd=%h gnt=%b rv=%b exp req=1 addr=2a wd=a5a50f0f gnt=%b rv=0",
                 i, o_mem_req, o_mem_addr, o_mem_wdata, o_cpu_gnt, o_cpu_rvalid, (i == 3));
      end
      if (i == 0) inject_rvalid = 1'b1;
    end
    ref_mem[32'h2A] = 32'hA5A5_0F0F;
    cpu_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (o_cpu_rvalid !== 1'b0 || o_dbg_rvalid !== 1'b0) begin
        errors++; $display("FAIL wait_stray_rvalid got %b%b exp 00", o_cpu_rvalid, o_dbg_rvalid);
      end
    end
  endtask

  task automatic test_reset_resp();
    rd_lat = 2;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd5;
    tick(); tick();
    vectors++;
    if (o_cpu_gnt !== 1'b1) begin errors++; $display("FAIL rresp_gnt got %b exp 1", o_cpu_gnt); end
    cpu_req = 1'b0; rst_n = 1'b0;
    tick();
    vectors++;
    if (o_busy !== 1'b1) begin errors++; $display("FAIL rresp_busy_resp got %b exp 1", o_busy); end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      vectors++;
      if ({o_cpu_rvalid, o_dbg_rvalid, o_busy, o_mem_req, o_cpu_gnt, o_cpu_rdata} !== {5'b0, 32'h0}) begin
        errors++;
        $display("FAIL rresp_after%0d got rv=%b drv=%b busy=%b mreq=%b gnt=%b rd=%h exp all 0",
                 i, o_cpu_rvalid, o_dbg_rvalid, o_busy, o_mem_req, o_cpu_gnt, o_cpu_rdata);
      end
      if (i == 1) inject_rvalid = 1'b1;
    end
    rd_lat = 0;
  endtask

  task automatic test_back_to_back();
    op_t cq[NOPS];
    op_t dq[NOPS];
    logic [31:0] c_exp[$];
    logic [31:0] d_exp[$];
    int unsigned ci = 0, di = 0;
    logic exp_dbg = 1'b0;
    logic [31:0] e;
    for (int i = 0; i < int'(NOPS); i++) begin
      cq[i] = {1'($urandom_range(0, 1)), 12'($urandom_range(0, 2047) * 2), 32'($urandom)};
      dq[i] = {1'($urandom_range(0, 1)), 12'($urandom_range(0, 2047) * 2 + 1), 32'($urandom)};
    end
    rd_lat = 1;
    do_reset();
    ready_rand = 1'b1;
    cpu_req = 1'b1; cpu_we = cq[0].we; cpu_addr = 32'(cq[0].addr); cpu_wdata = cq[0].data;
    dbg_req = 1'b1; dbg_we = dq[0].we; dbg_addr = 32'(dq[0].addr); dbg_wdata = dq[0].data;
    for (int c = 0; c < 2000 && (ci < NOPS || di < NOPS || c_exp.size() != 0 || d_exp.size() != 0); c++) begin
      tick();
      if (o_cpu_gnt && o_dbg_gnt) begin vectors++; errors++; $display("FAIL b2b_both_gnt got 11 exp one-hot"); end
      else if (o_cpu_gnt && ci < NOPS) begin
        vectors++;
        if (exp_dbg !== 1'b0 || {o_mem_we, o_mem_addr, o_mem_wdata} !== cq[ci]) begin
          errors++; $display("FAIL b2b_cpu_op%0d got cmd=%h exp owner_dbg=%b cmd=%h", ci,
                             {o_mem_we, o_mem_addr, o_mem_wdata}, exp_dbg, cq[ci]);
        end
        if (cq[ci].we) ref_mem[32'(cq[ci].addr)] = cq[ci].data;
        else c_exp.push_back(exp_val(32'(cq[ci].addr)));
        ci++;
        if (ci < NOPS) begin
          cpu_we = cq[ci].we; cpu_addr = 32'(cq[ci].addr); cpu_wdata = cq[ci].data;
        end else cpu_req = 1'b0;
        exp_dbg = (di < NOPS);
      end else if (o_dbg_gnt && di < NOPS) begin
        vectors++;
        if (exp_dbg !== 1'b1 || {o_mem_we, o_mem_addr, o_mem_wdata} !== dq[di]) begin
          errors++; $display("FAIL b2b_dbg_op%0d got cmd=%h exp owner_dbg=%b cmd=%h", di,
                             {o_mem_we, o_mem_addr, o_mem_wdata}, exp_dbg, dq[di]);
        end
        if (dq[di].we) ref_mem[32'(dq[di].addr)] = dq[di].data;
        else d_exp.push_back(exp_val(32'(dq[di].addr)));
        di++;
        if (di < NOPS) begin
          dbg_we = dq[di].we; dbg_addr = 32'(dq[di].addr); dbg_wdata = dq[di].data;
        end else dbg_req = 1'b0;
        exp_dbg = !(ci < NOPS);
      end
      if (o_cpu_rvalid) begin
        vectors++;
        e = (c_exp.size() != 0) ? c_exp.pop_front() : 32'hxxxx_xxxx;
        if (o_cpu_rdata !== e) begin errors++; $display("FAIL b2b_cpu_rdata got %h exp %h", o_cpu_rdata, e); end
      end
      if (o_dbg_rvalid) begin
        vectors++;
        e = (d_exp.size() != 0) ? d_exp.pop_front() : 32'hxxxx_xxxx;
        if (o_dbg_rdata !== e) begin errors++; $display("FAIL b2b_dbg_rdata got %h exp %h", o_dbg_rdata, e); end
      end
    end
    vectors++;
    if (ci != NOPS || di != NOPS || c_exp.size() != 0 || d_exp.size() != 0) begin
      errors++; $display("FAIL b2b_timeout got ci=%0d di=%0d pending=%0d/%0d exp %0d %0d 0/0",
                         ci, di, c_exp.size(), d_exp.size(), NOPS, NOPS);
    end
    ready_rand = 1'b0; rd_lat = 0;
  endtask

  task automatic test_range();
    ready_rand = 1'b0; mem_ready = 1'b1;
    tick();
`ifdef DMEM_RANGE_CHECK_EN
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd4096;
    tick(); tick();
    vectors++;
    if ({o_err, o_cpu_gnt, o_mem_req, o_dbg_gnt} !== 4'b1100) begin
      errors++; $display("FAIL range_load_reject got err/gnt/mreq/dgnt=%b exp 1100", {o_err, o_cpu_gnt, o_mem_req, o_dbg_gnt});
    end
    cpu_req = 1'b0;
    tick();
    vectors++;
    if ({o_cpu_rvalid, o_cpu_rdata, o_err, o_busy} !== {1'b1, 32'h0, 2'b00}) begin
      errors++; $display("FAIL range_load_return got rv=%b rd=%h err=%b busy=%b exp 1 0 0 0",
                         o_cpu_rvalid, o_cpu_rdata, o_err, o_busy);
    end
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'd5000; cpu_wdata = 32'hBAD0_BAD0;
    tick(); tick();
    vectors++;
    if ({o_err, o_cpu_gnt, o_mem_req} !== 3'b110) begin
      errors++; $display("FAIL range_store_reject got err/gnt/mreq=%b exp 110", {o_err, o_cpu_gnt, o_mem_req});
    end
    cpu_req = 1'b0;
    tick();
    vectors++;
    if (o_cpu_rvalid !== 1'b0) begin errors++; $display("FAIL range_store_rvalid got %b exp 0", o_cpu_rvalid); end
    for (int k = 0; k < 2; k++) begin
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = (k == 0) ? 32'd4095 : 32'd904;
      tick(); tick();
      vectors++;
      if ({o_err, o_cpu_gnt, o_mem_req, o_mem_addr} !== {3'b011, cpu_addr[11:0]}) begin
        errors++; $display("FAIL range_inbound%0d got err/gnt/mreq=%b addr=%0d exp 011 addr=%0d",
                           k, {o_err, o_cpu_gnt, o_mem_req}, o_mem_addr, cpu_addr);
      end
      cpu_req = 1'b0;
      tick(); tick();
      vectors++;
      if (o_cpu_rvalid !== 1'b1 || o_cpu_rdata !== exp_val(cpu_addr)) begin
        errors++; $display("FAIL range_inbound%0d_data got rv=%b rd=%h exp rv=1 rd=%h",
                           k, o_cpu_rvalid, o_cpu_rdata, exp_val(cpu_addr));
      end
    end
`else
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'd4105; cpu_wdata = 32'h7E57_0009;
    tick(); tick();
    vectors++;
    if ({o_err, o_cpu_gnt, o_mem_req, o_mem_addr} !== {3'b011, 12'd9}) begin
      errors++; $display("FAIL trunc_store got err/gnt/mreq=%b addr=%0d exp 011 addr=9",
                         {o_err, o_cpu_gnt, o_mem_req}, o_mem_addr);
    end
    ref_mem[9] = 32'h7E57_0009;
    cpu_req = 1'b0;
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd9;
    tick(); tick();
    cpu_req = 1'b0;
    tick(); tick();
    vectors++;
    if (o_cpu_rvalid !== 1'b1 || o_cpu_rdata !== exp_val(9) || o_err !== 1'b0) begin
      errors++; $display("FAIL trunc_load got rv=%b rd=%h err=%b exp rv=1 rd=%h err=0",
                         o_cpu_rvalid, o_cpu_rdata, o_err, exp_val(9));
    end
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
    pend = 1'b0; pend_addr = '0; inject_rvalid = 1'b0; ready_rand = 1'b0;
    rd_lat = 0; lat_cnt = 0; stall_cnt = 0;
    for (int i = 0; i < 4096; i++) mem_arr[i] = init_pat(i);
    test_reset();
    test_store_load();
    test_contention();
    test_wait_states();
    test_reset_resp();
    test_back_to_back();
    test_range();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters:
  - the processor's lw/sw port (CPU, index 0);
  - the test/debug loader port (DBG, index 1), used to preload and dump memory.
- Round-robin arbitration, one outstanding transaction at a time.
- Decoupled memory handshake (mem_ready accept, mem_rvalid read return), so a multi-cycle memory can replace the single-cycle array without touching the core.

Parameters:
- ADDR_W, 32, requester word-address width (CPU computes rs+imm at full width)
- MEM_AW, 12, memory word-address width
- DEPTH, 4096, number of valid memory words
- DATA_W, 32, data width

Ports:
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- cpu_req  input  1  CPU request, held until cpu_gnt
- cpu_we  input  1  1=store, 0=load
- cpu_addr  input  ADDR_W  word address
- cpu_wdata  input  DATA_W  store data
- cpu_gnt  output  1  one-cycle pulse: request accepted
- cpu_rvalid  output  1  one-cycle pulse: load data valid
- cpu_rdata  output  DATA_W  load data, held until next CPU load return
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata: same as cpu_* for the DBG requester
- mem_req  output  1  memory request
- mem_we  output  1  memory write enable
- mem_addr  output  MEM_AW  memory word address
- mem_wdata  output  DATA_W  memory write data
- mem_ready  input  1  memory accepts request this cycle
- mem_rvalid  input  1  read data valid
- mem_rdata  input  DATA_W  read data
- busy  output  1  state != IDLE
- err  output  1  out-of-range pulse (see Optional Feature)

Behaviour:
- Reset is synchronous: rst_n low at a rising edge forces:
  - state=IDLE;
  - all gnt, rvalid, mem_req, busy and err outputs to 0;
  - rdata registers to 0;
  - last_owner=DBG, so CPU wins the first tie.
- FSM states are IDLE, ISSUE and RESP.
- IDLE:
  - If any req is high, select the owner: a single requester wins; if both are high, the requester that is not last_owner wins.
  - Latch owner, we, addr and wdata into a registered command; next state ISSUE.
  - With no request, stay in IDLE.
- ISSUE:
  - mem_req=1; mem_we, mem_addr and mem_wdata come from the registered command. mem_addr = addr[MEM_AW-1:0].
  - When mem_ready=1, the owner's gnt is asserted combinationally in the same cycle and last_owner is updated.
  - On accept, a store goes to IDLE and a load goes to RESP.
  - If mem_ready=0, stay in ISSUE with the command held stable.
- RESP:
  - mem_req=0. On mem_rvalid=1, capture mem_rdata into the owner's rdata register.
  - The owner's rvalid pulses high in the next cycle (registered); next state IDLE.
- Minimum latency, for a request first seen at cycle N with a zero-wait memory:
  - Store: gnt at N+1, next arbitration at N+2.
  - Load: gnt at N+1, mem_rvalid at N+2, rvalid and rdata at N+3.
- A requester must hold req, we, addr and wdata until its gnt. Dropping req after it was latched does not cancel the transaction.
- gnt goes only to the owner; the other requester's gnt and rvalid stay 0.
- mem_rvalid in IDLE or ISSUE is ignored and produces no rvalid.
- Back-to-back requests from both requesters strictly alternate owners.
- Reset mid-transaction: return to IDLE, drop mem_req immediately, discard any later mem_rvalid, and issue no gnt or rvalid for the aborted command.

Optional Feature:
- Macro: DMEM_RANGE_CHECK_EN.
- Defined:
  - In ISSUE, a command with addr >= DEPTH (unsigned compare at ADDR_W bits) does not assert mem_req.
  - The owner's gnt and err pulse together in the first ISSUE cycle.
  - A store is dropped and the FSM returns to IDLE.
  - A load returns rvalid the next cycle with rdata=0, then IDLE.
- Undefined: err is tied 0 and the address is truncated to MEM_AW bits with no check.

Test Plan:
- Reset: rst_n=0 for 2 cycles with cpu_req=1 -> busy, mem_req, cpu_gnt and cpu_rvalid all 0; after release, cpu_gnt at the 2nd cycle.
- CPU store then load: store addr 5, data 0x1234_5678, with mem_ready=1 -> mem_we=1, mem_addr=5, cpu_gnt 1 cycle. Then load addr 5 -> cpu_rvalid 3 cycles after req with cpu_rdata=0x1234_5678.
- Contention: cpu_req and dbg_req held high for 4 stores -> grants in the order CPU, DBG, CPU, DBG, never both in one cycle.
- Wait states: mem_ready low for 3 cycles in ISSUE -> mem_req and mem_addr stable for 4 cycles, gnt on the 4th only.
- Reset during RESP: then mem_rvalid=1 after release -> no rvalid, busy=0.
- With DMEM_RANGE_CHECK_EN: CPU load addr 4096 -> err and cpu_gnt pulse, no mem_req, cpu_rvalid next cycle with rdata=0. Addr 4095 -> normal access.
